pipe_stage: RTL
===============

PIPE_STAGE -- requirements
Module: pipe_stage

Interface
REQ-001 Parameter DATA_W, default 64: payload width in bits, legal range 1..256.
REQ-002 Parameter SKID, default 1: 1 = two-entry skid mode with registered in_ready; 0 = single-entry mode with combinational in_ready.
REQ-003 Parameter CNT_W, default 16: width of the stall counter.
REQ-004 clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 in_valid  input  1  upstream beat present.
REQ-007 in_ready  output  1  stage can accept a beat this cycle.
REQ-008 in_data  input  DATA_W  upstream payload.
REQ-009 in_halt  input  1  beat carries a halt marker.
REQ-010 out_valid  output  1  downstream beat present, driven from a register.
REQ-011 out_ready  input  1  downstream accepts this cycle.
REQ-012 out_data  output  DATA_W  payload of the oldest held beat, driven from a register.
REQ-013 out_halt  output  1  halt marker of the oldest held beat.
REQ-014 flush  input  1  synchronous discard of all held beats.
REQ-015 halted  output  1  sticky flag: a halt beat has been accepted.
REQ-016 stall_cnt  output  CNT_W  count of back-pressured cycles.
REQ-017 err  output  1  one-cycle pulse on an upstream protocol violation.

Function
REQ-018 An accept occurs on in_valid && in_ready; a drain occurs on out_valid && out_ready.
REQ-019 States: EMPTY, ONE (main entry full), TWO (main and skid entries full; SKID=1 only).
REQ-020 Transitions: EMPTY->ONE on accept; ONE->EMPTY on drain without accept; ONE->ONE on accept with drain; ONE->TWO on accept without drain; TWO->ONE on drain, with skid contents moving to main.
REQ-021 Latency: a beat accepted in an EMPTY-state cycle N appears on out_valid/out_data in cycle N+1.
REQ-022 Beats leave in acceptance order; no beat is duplicated or lost except by flush.
REQ-023 SKID=1: in_ready is registered and equals (state != TWO) && !halted.
REQ-024 SKID=0: in_ready = (state == EMPTY || out_ready) && !halted, combinationally; state TWO is unreachable.
REQ-025 out_valid = (state != EMPTY); out_data and out_halt are undefined but stable while out_valid is 0.
REQ-026 An accepted beat with in_halt=1 sets halted from the next cycle; in_ready is then 0, and held beats still drain normally.
REQ-027 halted clears only on reset or flush.
REQ-028 flush has highest priority: the next state is EMPTY and halted is 0; any accept in the flush cycle is discarded; any drain in the flush cycle still counts downstream.
REQ-029 stall_cnt increments by 1 in each cycle with out_valid && !out_ready, saturates at 2^CNT_W-1, and is unaffected by flush.
REQ-030 err pulses high for one cycle after cycle N+1 if cycle N had in_valid && !in_ready && !flush and cycle N+1 has in_valid==0 or in_data changed; this check is not made in a cycle where flush=1.
REQ-031 Throughput: with out_ready held at 1 and SKID=1, one beat per cycle is sustained indefinitely.

Reset
REQ-032 While rst=0: state EMPTY, out_valid=0, halted=0, stall_cnt=0, err=0, in_ready=0, and out_data/out_halt are 0.
REQ-033 in_ready first rises in the first clock after rst deasserts; reset asserted mid-transfer discards all held beats immediately.

Verification
REQ-034 SKID=1, DATA_W=16, out_ready=1: stream 0x0001..0x0010 back-to-back -> out_data 0x0001..0x0010 on consecutive cycles, one cycle late; in_ready constant 1.
REQ-035 SKID=1: accept 0xAAAA then 0xBBBB with out_ready=0 -> state TWO, in_ready=0 next cycle; after 3 stalled cycles, stall_cnt=3; raise out_ready -> 0xAAAA then 0xBBBB drained in order.
REQ-036 SKID=0: out_ready=0 while full -> in_ready=0 in the same cycle; raise out_ready with in_valid=1 -> drain and accept in the same cycle.
REQ-037 Accept a beat with in_halt=1 -> halted=1 and in_ready=0 next cycle; the beat drains with out_halt=1; assert flush -> halted=0, in_ready=1.
REQ-038 Hold in_valid=1 while in_ready=0, then change in_data -> err=1 for exactly one cycle; repeat with flush=1 in the same cycle -> err stays 0.
REQ-039 CNT_W=4, hold out_ready=0 with out_valid=1 for 20 cycles -> stall_cnt saturates at 15; pulse rst low mid-stream -> all outputs at reset values immediately.

Source files
------------

// File: rtl/pipe_stage.sv
// Purpose : elastic pipeline register stage with optional skid entry, halt marker, stall counter and protocol checker.
// Latency : 1 cycle from accept to out_valid/out_data when the stage is empty.
// Backpr. : SKID=1 -> registered in_ready, two entries absorb one cycle of out_ready=0; SKID=0 -> one entry, in_ready follows out_ready combinationally.
//
// Ports:
//   clk, rst (async, active-low)
//   in_valid/in_ready/in_data/in_halt    upstream beat handshake
//   out_valid/out_ready/out_data/out_halt downstream beat handshake (out_* registered)
//   flush      synchronous discard of all held beats, clears halted
//   halted     sticky: a halt-marked beat has been accepted
//   stall_cnt  saturating count of cycles with out_valid && !out_ready
//   err        one-cycle pulse when upstream drops or changes a beat that was not accepted
module pipe_stage #(
    parameter int DATA_W = 64,
    parameter int SKID   = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_halt,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_halt,
    input  logic              flush,
    output logic              halted,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic              err
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [DATA_W-1:0]  skid_data;
    logic               skid_halt;
    logic               halted_nxt;
    logic               rdy_q;      // registered in_ready for skid mode
    logic               live_q;     // low until the first clock after reset
    logic               comb_rdy;   // combinational in_ready for single-entry mode
    logic               acc;
    logic               drn;
    logic               ld_main_in;
    logic               ld_main_skid;
    logic               ld_skid;
    logic               viol_q;     // previous cycle offered a beat that was refused
    logic [DATA_W-1:0]  viol_data_q;

    assign comb_rdy = ((state == EMPTY) || out_ready) && !halted && live_q;
    assign in_ready = (SKID != 0) ? rdy_q : comb_rdy;

    assign acc = in_valid && in_ready;
    assign drn = out_valid && out_ready;

    // Flush wins over everything; an accept in the flush cycle is dropped.
    assign halted_nxt = flush ? 1'b0 : (halted || (acc && in_halt));

    always_comb begin
        state_nxt    = state;
        ld_main_in   = 1'b0;
        ld_main_skid = 1'b0;
        ld_skid      = 1'b0;
        if (flush) begin
            state_nxt = EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (acc) begin
                        state_nxt  = ONE;
                        ld_main_in = 1'b1;
                    end
                end
                ONE: begin
                    if (acc && drn) begin
                        ld_main_in = 1'b1;
                    end else if (acc && (SKID != 0)) begin
                        // Downstream stalled: park the new beat behind the main entry.
                        state_nxt = TWO;
                        ld_skid   = 1'b1;
                    end else if (drn) begin
                        state_nxt = EMPTY;
                    end
                end
                TWO: begin
                    // in_ready is low here, so only a drain can happen.
                    if (drn) begin
                        state_nxt    = ONE;
                        ld_main_skid = 1'b1;
                    end
                end
                default: state_nxt = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= EMPTY;
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_halt    <= 1'b0;
            skid_data   <= '0;
            skid_halt   <= 1'b0;
            halted      <= 1'b0;
            rdy_q       <= 1'b0;
            live_q      <= 1'b0;
            stall_cnt   <= '0;
            err         <= 1'b0;
            viol_q      <= 1'b0;
            viol_data_q <= '0;
        end else begin
            state     <= state_nxt;
            out_valid <= (state_nxt != EMPTY);
            halted    <= halted_nxt;
            live_q    <= 1'b1;
            // Registered ready looks ahead at the next state so it is exact, not one cycle stale.
            rdy_q     <= (state_nxt != TWO) && !halted_nxt;

            if (ld_main_in) begin
                out_data <= in_data;
                out_halt <= in_halt;
            end else if (ld_main_skid) begin
                out_data <= skid_data;
                out_halt <= skid_halt;
            end

            if (ld_skid) begin
                skid_data <= in_data;
                skid_halt <= in_halt;
            end

            // Back-pressure counter keeps running through flush.
            if (out_valid && !out_ready && (stall_cnt != {CNT_W{1'b1}})) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end

            // A refused beat must be held unchanged; dropping or altering it is flagged.
            err         <= !flush && viol_q && (!in_valid || (in_data != viol_data_q));
            viol_q      <= in_valid && !in_ready && !flush;
            viol_data_q <= in_data;
        end
    end

endmodule
